// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, control bundle type and helpers for pipe_hazard_ctrl.
package pipe_hazard_ctrl_pkg;

    localparam logic [0:0] PH_RUN      = 1'b0;
    localparam logic [0:0] PH_MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic memwb_en;
        logic memwb_bubble;
        logic dmem_req;
    } ph_ctrl_t;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
        if (hit_mem) return FWD_MEM;
        if (hit_wb)  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode, data-memory handshake and pipeline-control bundle between the core
// datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned STALL_CNT_W  = 32
);
    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_rs1;
    logic [REG_ADDR_LEN-1:0] id_rs2;
    logic                    id_use_rs1;
    logic                    id_use_rs2;
    logic [REG_ADDR_LEN-1:0] id_rd;
    logic                    id_rf_w_en;
    logic                    id_is_load;
    logic                    id_is_mem;
    logic                    id_is_branch;
    logic                    id_redirect;
    logic                    dmem_ready;

    logic                    dmem_req;
    logic                    pc_en;
    logic                    ifid_en;
    logic                    ifid_flush;
    logic                    idex_en;
    logic                    idex_bubble;
    logic                    exmem_en;
    logic                    memwb_en;
    logic                    memwb_bubble;
    logic [1:0]              fwd_a;
    logic [1:0]              fwd_b;
    logic [STALL_CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rf_w_en, id_is_load, id_is_mem, id_is_branch, id_redirect,
               dmem_ready,
        input  dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_en, memwb_bubble, fwd_a, fwd_b, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rf_w_en, id_is_load, id_is_mem, id_is_branch, id_redirect,
               dmem_ready,
        output dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_en, memwb_bubble, fwd_a, fwd_b, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Compares one decode source register against the EX/MEM/WB shadow entries;
// hit is {hit_ex, hit_mem, hit_wb}.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic [REG_ADDR_LEN-1:0] src,
    input  logic                    use_src,
    input  logic                    ex_valid,
    input  logic                    ex_wr,
    input  logic [REG_ADDR_LEN-1:0] ex_rd,
    input  logic                    mem_valid,
    input  logic                    mem_wr,
    input  logic [REG_ADDR_LEN-1:0] mem_rd,
    input  logic                    wb_valid,
    input  logic                    wb_wr,
    input  logic [REG_ADDR_LEN-1:0] wb_rd,
    output logic [2:0]              hit
);

    always_comb begin
        hit    = '0;
        hit[2] = use_src & ex_valid  & ex_wr  & (ex_rd  == src);
        hit[1] = use_src & mem_valid & mem_wr & (mem_rd == src);
        hit[0] = use_src & wb_valid  & wb_wr  & (wb_rd  == src);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order 5-stage pipeline sequencer: RAW hazard interlock, memory freeze,
// redirect flush and stage enables. Optional EX forwarding: PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned STALL_CNT_W  = 32
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic                    valid;
        logic                    wr;
        logic [REG_ADDR_LEN-1:0] rd;
        logic                    is_load;
        logic                    is_mem;
        logic [REG_ADDR_LEN-1:0] rs1;
        logic [REG_ADDR_LEN-1:0] rs2;
        logic                    use_rs1;
        logic                    use_rs2;
    } entry_t;

    entry_t                 ex_q, ex_d;
    entry_t                 mem_q, mem_d;
    entry_t                 wb_q, wb_d;
    entry_t                 id_entry;
    logic [0:0]             state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]             hit_rs1, hit_rs2;
    logic                   frz;
    logic                   haz;
    ph_ctrl_t               ctrl;
    logic [1:0]             fwd_a, fwd_b;
    logic                   unused_sink;

    always_comb begin
        id_entry         = '0;
        id_entry.valid   = 1'b1;
        id_entry.wr      = bus.id_rf_w_en & (bus.id_rd != '0);
        id_entry.rd      = bus.id_rd;
        id_entry.is_load = bus.id_is_load;
        id_entry.is_mem  = bus.id_is_mem;
        id_entry.rs1     = bus.id_rs1;
        id_entry.rs2     = bus.id_rs2;
        id_entry.use_rs1 = bus.id_use_rs1;
        id_entry.use_rs2 = bus.id_use_rs2;
    end

    hazard_cmp #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_cmp_rs1 (
        .src       (bus.id_rs1),
        .use_src   (bus.id_use_rs1),
        .ex_valid  (ex_q.valid),
        .ex_wr     (ex_q.wr),
        .ex_rd     (ex_q.rd),
        .mem_valid (mem_q.valid),
        .mem_wr    (mem_q.wr),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wr     (wb_q.wr),
        .wb_rd     (wb_q.rd),
        .hit       (hit_rs1)
    );

    hazard_cmp #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_cmp_rs2 (
        .src       (bus.id_rs2),
        .use_src   (bus.id_use_rs2),
        .ex_valid  (ex_q.valid),
        .ex_wr     (ex_q.wr),
        .ex_rd     (ex_q.rd),
        .mem_valid (mem_q.valid),
        .mem_wr    (mem_q.wr),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wr     (wb_q.wr),
        .wb_rd     (wb_q.rd),
        .hit       (hit_rs2)
    );

    // Branches compare operands in ID, so they always interlock on any writer.
`ifdef PIPE_HAZARD_FWD_EN
    always_comb begin
        if (bus.id_is_branch) begin
            haz = bus.id_valid & (|{hit_rs1, hit_rs2});
        end else begin
            haz = bus.id_valid & (hit_rs1[2] | hit_rs2[2]) & ex_q.is_load;
        end
    end
`else
    always_comb begin
        haz = bus.id_valid & (|{hit_rs1, hit_rs2});
    end
`endif

    always_comb begin
        frz = mem_q.valid & mem_q.is_mem & ~bus.dmem_ready;
    end

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl.dmem_req = mem_q.valid & mem_q.is_mem;
            if (frz) begin
                ctrl.memwb_bubble = 1'b1;
            end else if (haz) begin
                ctrl.idex_en     = 1'b1;
                ctrl.idex_bubble = 1'b1;
                ctrl.exmem_en    = 1'b1;
                ctrl.memwb_en    = 1'b1;
            end else begin
                ctrl.pc_en      = 1'b1;
                ctrl.ifid_en    = 1'b1;
                ctrl.idex_en    = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
                ctrl.ifid_flush = bus.id_redirect & bus.id_valid;
            end
        end
    end

    // A frozen MEM stage keeps EX/MEM; WB drains so the write is not repeated.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (frz) begin
            wb_d = '0;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = (haz || !bus.id_valid) ? '0 : id_entry;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == PH_RUN) begin
            if (frz) state_d = PH_MEM_WAIT;
        end else begin
            if (bus.dmem_ready) state_d = PH_RUN;
        end

        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= PH_RUN;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    // A load in MEM has no data yet; load-use stalls keep that case from arising.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset && ex_q.valid) begin
            fwd_a = fwd_sel(
                mem_q.valid & mem_q.wr & ~mem_q.is_load & ex_q.use_rs1 & (mem_q.rd == ex_q.rs1),
                wb_q.valid & wb_q.wr & ex_q.use_rs1 & (wb_q.rd == ex_q.rs1));
            fwd_b = fwd_sel(
                mem_q.valid & mem_q.wr & ~mem_q.is_load & ex_q.use_rs2 & (mem_q.rd == ex_q.rs2),
                wb_q.valid & wb_q.wr & ex_q.use_rs2 & (wb_q.rd == ex_q.rs2));
        end
    end
`else
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end
`endif

    // Entry fields not consumed in every build configuration.
    assign unused_sink = ^{ex_q, mem_q, wb_q, bus.id_is_branch};

    assign bus.dmem_req     = ctrl.dmem_req;
    assign bus.pc_en        = ctrl.pc_en;
    assign bus.ifid_en      = ctrl.ifid_en;
    assign bus.ifid_flush   = ctrl.ifid_flush;
    assign bus.idex_en      = ctrl.idex_en;
    assign bus.idex_bubble  = ctrl.idex_bubble;
    assign bus.exmem_en     = ctrl.exmem_en;
    assign bus.memwb_en     = ctrl.memwb_en;
    assign bus.memwb_bubble = ctrl.memwb_bubble;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.stall_cycles = stall_cnt_q;

endmodule
